// File: rtl/seq_div_if.sv
// Divider handshake bundle: start/operands in, busy/done/results out.
interface seq_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Radix-2 restoring divider, one quotient bit per cycle, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; default is unsigned.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one shift/trial-subtract per cycle, WIDTH iterations
// FIX   | sign correction / divide-by-zero override, results registered
module seq_div #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   reset,
  seq_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] a_lat;
  logic             b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH+1:0] rem_sh, trial;
  logic             trial_neg;
  logic [WIDTH:0]   rem_next;
  logic             done_q, dz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Magnitudes are WIDTH-bit unsigned, so negating MIN yields 2^(WIDTH-1) exactly.
  assign mag_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign mag_b = bus.B[WIDTH-1] ? -bus.B : bus.B;
  assign q_fix = neg_q ? -dq : dq;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`else
  assign mag_a = bus.A;
  assign mag_b = bus.B;
  assign q_fix = dq;
  assign r_fix = rem[WIDTH-1:0];
`endif

  assign rem_sh    = {rem, dq[WIDTH-1]};
  assign trial     = rem_sh - {2'b00, divisor};
  assign trial_neg = trial[WIDTH+1];
  assign rem_next  = trial_neg ? rem_sh[WIDTH:0] : trial[WIDTH:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: if (count == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      count       <= '0;
      rem         <= '0;
      dq          <= '0;
      divisor     <= '0;
      a_lat       <= '0;
      b_zero      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        dq      <= mag_a;
        divisor <= mag_b;
        rem     <= '0;
        count   <= CW'(WIDTH);
        a_lat   <= bus.A;
        b_zero  <= (bus.B == '0);
`ifdef SEQ_DIV_SIGNED_EN
        neg_q   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        neg_r   <= bus.A[WIDTH-1];
`endif
      end else if (state == CALC) begin
        rem   <= rem_next;
        dq    <= {dq[WIDTH-2:0], ~trial_neg};
        count <= count - CW'(1);
      end else if (state == FIX) begin
        // Divide by zero keeps full latency; only the result values are overridden.
        done_q      <= 1'b1;
        dz_q        <= b_zero;
        quotient_q  <= b_zero ? '1 : q_fix;
        remainder_q <= b_zero ? a_lat : r_fix;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
endmodule
